// File: rtl/can_tx_field_seq.sv
// CAN transmit field sequencer: steps SOF..IFS once per sample point and schedules stuff bits.
// Outputs are registered and describe the current bit time; there is no backpressure.
module can_tx_field_seq #(
  parameter int STUFF_LEN = 5,
  parameter int EOF_BITS  = 7,
  parameter int IFS_BITS  = 3
) (
  input  logic       sp,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       rtr,
  input  logic [3:0] dlc,
  input  logic       tx_bit,
  output logic [3:0] field,
  output logic [6:0] field_idx,
  output logic       is_stuff,
  output logic       stuff_val,
  output logic       busy,
  output logic       frame_done
);

  localparam int RW = $clog2(STUFF_LEN + 1);

  typedef enum logic [3:0] {
    F_IDLE    = 4'd0,
    F_SOF     = 4'd1,
    F_ID      = 4'd2,
    F_RTR     = 4'd3,
    F_IDE     = 4'd4,
    F_R0      = 4'd5,
    F_DLC     = 4'd6,
    F_DATA    = 4'd7,
    F_CRC     = 4'd8,
    F_CRC_DEL = 4'd9,
    F_ACK     = 4'd10,
    F_ACK_DEL = 4'd11,
    F_EOF     = 4'd12,
    F_IFS     = 4'd13
  } field_t;

  field_t        fs, fs_n;
  logic [6:0]    idx, idx_n;
  logic          stf, stf_n;
  logic          sv, sv_n;
  logic          done, done_n;
  logic [RW-1:0] run, run_n;
  logic [RW-1:0] run_upd;
  logic          last, last_n;
  logic [3:0]    nbytes, nbytes_n;

  function automatic logic [6:0] field_len(input field_t f, input logic [3:0] n);
    case (f)
      F_ID:    field_len = 7'd11;
      F_DLC:   field_len = 7'd4;
      F_DATA:  field_len = {n, 3'b000};
      F_CRC:   field_len = 7'd15;
      F_EOF:   field_len = 7'(EOF_BITS);
      F_IFS:   field_len = 7'(IFS_BITS);
      default: field_len = 7'd1;
    endcase
  endfunction

  always_comb begin
    fs_n     = fs;
    idx_n    = idx;
    stf_n    = 1'b0;
    sv_n     = 1'b0;
    done_n   = 1'b0;
    run_n    = run;
    last_n   = last;
    nbytes_n = nbytes;
    run_upd  = '0;
    if (fs == F_IDLE) begin
      if (start) begin
        fs_n     = F_SOF;
        idx_n    = 7'd0;
        run_n    = '0;
        nbytes_n = rtr ? 4'd0 : ((dlc > 4'd8) ? 4'd8 : dlc);
      end
    end else if (abort) begin
      fs_n   = F_IDLE;
      idx_n  = 7'd0;
      run_n  = '0;
      last_n = 1'b1;
    end else if (stf) begin
      // The stuff bit itself seeds the next run; field/idx already name the pending bit.
      run_n  = RW'(1);
      last_n = sv;
    end else begin
      if (idx == field_len(fs, nbytes) - 7'd1) begin
        idx_n = 7'd0;
        if (fs == F_IFS) begin
          fs_n   = F_IDLE;
          done_n = 1'b1;
        end else if (fs == F_DLC && nbytes == 4'd0) begin
          fs_n = F_CRC;
        end else begin
          fs_n = field_t'(fs + 4'd1);
        end
      end else begin
        idx_n = idx + 7'd1;
      end
      if (fs <= F_CRC) begin
        run_upd = (tx_bit == last) ? RW'(run + 1'b1) : RW'(1);
        run_n   = run_upd;
        last_n  = tx_bit;
        if (run_upd == RW'(STUFF_LEN)) begin
          stf_n = 1'b1;
          sv_n  = ~tx_bit;
        end
      end else begin
        run_n = '0;
      end
    end
  end

  always_ff @(posedge sp) begin
    if (reset) begin
      fs     <= F_IDLE;
      idx    <= 7'd0;
      stf    <= 1'b0;
      sv     <= 1'b0;
      done   <= 1'b0;
      run    <= '0;
      last   <= 1'b1;
      nbytes <= 4'd0;
    end else begin
      fs     <= fs_n;
      idx    <= idx_n;
      stf    <= stf_n;
      sv     <= sv_n;
      done   <= done_n;
      run    <= run_n;
      last   <= last_n;
      nbytes <= nbytes_n;
    end
  end

  assign field      = fs;
  assign field_idx  = idx;
  assign is_stuff   = stf;
  assign stuff_val  = sv;
  assign busy       = (fs != F_IDLE);
  assign frame_done = done;

endmodule
